rcb_frl_tx_link_ctrl: RTL and testbench
=======================================

# rcb_frl_tx_link_ctrl

Transmit-side link-training sequencer for the Fast Radio Link. It owns the 8-bit training-pattern generator, which produces the alternating 0xF4/0xC2 stream. It also owns the user TX byte stream, and multiplexes one of these onto the serializer byte lane. Its state machine runs a fixed training burst, waits for the peer receiver to report lock, emits a sync marker, then opens the data path. It returns to training on request, on loss of peer lock, or on lock timeout.

## Interface
Parameters:
- TRAIN_CYCLES, 256: minimum training-burst length in cycles (≥2).
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before retraining (≥1).
- SYNC_LEN, 4: number of SYNC_WORD bytes sent before link-up (≥1).
- SYNC_WORD, 8'h5A: sync marker byte.
- IDLE_WORD, 8'h00: byte sent in UP when no user data is valid.

Ports:
- CLK, in, 1: clock.
- RST, in, 1: reset, synchronous, active-high.
- LINK_EN, in, 1: enables the link; when low, the block is forced to OFF.
- RETRAIN, in, 1: single-cycle or level request to restart training.
- PEER_LOCKED, in, 1: peer receiver aligned, already synchronized to CLK.
- TP_RST, out, 1: reset to the training-pattern generator.
- TP_DATA, in, 8: generator output.
- TX_DATA_IN, in, 8: user byte.
- TX_VALID, in, 1: user byte valid.
- TX_READY, out, 1: user byte accepted this cycle.
- DATA_OUT, out, 8: registered byte lane to the serializer.
- LINK_UP, out, 1: high in UP.
- TRAIN_ACTIVE, out, 1: high in TRAIN or WAIT_LOCK.
- TIMEOUT_ERR, out, 1: sticky lock-timeout flag.

## Operation
- States: OFF, TRAIN, WAIT_LOCK, SYNC, UP. State, counters, DATA_OUT and TIMEOUT_ERR are registered.
- TP_RST, LINK_UP, TRAIN_ACTIVE and TX_READY are decoded from the state register only:
  - TP_RST = 1 in OFF, SYNC and UP.
  - TX_READY = 1 in UP only.
- One shared counter `cnt`, sized to clog2 of the largest parameter. It is cleared on every state change.
- OFF:
  - DATA_OUT <= 0.
  - If LINK_EN = 1, go to TRAIN.
- TRAIN:
  - DATA_OUT <= TP_DATA.
  - When cnt == TRAIN_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK:
  - DATA_OUT <= TP_DATA.
  - If PEER_LOCKED = 1, go to SYNC.
  - Otherwise, when cnt == LOCK_TIMEOUT-1, set TIMEOUT_ERR and go to TRAIN.
- SYNC:
  - DATA_OUT <= SYNC_WORD.
  - When cnt == SYNC_LEN-1, go to UP.
  - PEER_LOCKED = 0 in SYNC sends the block to TRAIN.
- UP:
  - DATA_OUT <= TX_VALID ? TX_DATA_IN : IDLE_WORD.
  - RETRAIN = 1 or PEER_LOCKED = 0 sends the block to TRAIN.
- Transition priority, highest first:
  1. RST
  2. LINK_EN = 0 (go to OFF)
  3. RETRAIN = 1 (go to TRAIN with cnt cleared; applies from TRAIN, WAIT_LOCK, SYNC or UP)
  4. Lock loss
  5. Normal transitions
- RETRAIN in TRAIN restarts the burst count.
- Simultaneous PEER_LOCKED rise and timeout in WAIT_LOCK: lock wins, go to SYNC, TIMEOUT_ERR unchanged.
- TIMEOUT_ERR is cleared only by RST or LINK_EN = 0.

## Timing
- Reset values:
  - State OFF, cnt = 0.
  - DATA_OUT = 0x00, TIMEOUT_ERR = 0.
  - TP_RST = 1, all other outputs 0.
- Entering TRAIN at cycle T0 releases TP_RST during T0. The generator still holds 0x00 during T0, so DATA_OUT shows:
  - 0x00 at T0+1
  - 0xF4 at T0+2
  - 0xC2 at T0+3, then alternating.
- TRAIN lasts exactly TRAIN_CYCLES cycles when undisturbed.
- WAIT_LOCK reaction:
  - PEER_LOCKED sampled high at cycle W gives state SYNC at W+1.
  - The first SYNC_WORD appears on DATA_OUT at W+2.
- User-data latency is 1 cycle: a byte with TX_VALID & TX_READY at cycle n appears on DATA_OUT at n+1. No backpressure exists within UP.
- A lock timeout asserts TIMEOUT_ERR one cycle after cnt == LOCK_TIMEOUT-1, together with state TRAIN.
- Reset mid-operation: all outputs return to their reset values at the next edge, and any in-flight user byte is dropped.

## Test plan
- Bring-up: RST for 4 cycles, LINK_EN = 1, PEER_LOCKED = 1 throughout, TRAIN_CYCLES = 8, SYNC_LEN = 4.
  - DATA_OUT = 00, F4, C2, F4, C2, F4, C2, F4 (8 bytes).
  - Then WAIT_LOCK for one cycle, carrying the next training byte, C2.
  - Then 5A×4, then LINK_UP = 1 and TX_READY = 1.
- Data path in UP: drive TX_VALID with bytes 0x11, 0x22, a gap, then 0x33.
  - DATA_OUT = 11, 22, 00, 33, each one cycle after its input.
- Timeout: PEER_LOCKED = 0, LOCK_TIMEOUT = 16.
  - TIMEOUT_ERR rises after 16 WAIT_LOCK cycles and the state returns to TRAIN.
  - TIMEOUT_ERR stays 1 until LINK_EN = 0, then clears.
- Lock loss in UP: drop PEER_LOCKED for 1 cycle.
  - TX_READY = 0 and TRAIN_ACTIVE = 1 next cycle, and training restarts from 0x00.
- Priority: assert RETRAIN and LINK_EN = 0 in the same cycle while in UP.
  - State is OFF, DATA_OUT = 0x00 and TP_RST = 1.
  - Assert RETRAIN mid-TRAIN: the burst restarts with a full TRAIN_CYCLES count.
- Simultaneous PEER_LOCKED rise and timeout in WAIT_LOCK: the state goes to SYNC and TIMEOUT_ERR stays 0.

Source files
------------

// File: rtl/rcb_frl_tx_link_ctrl.sv
// Transmit-side link-training sequencer: drives the training pattern, then a sync
// marker, then user bytes onto the registered serializer lane.
module rcb_frl_tx_link_ctrl #(
    parameter int          TRAIN_CYCLES = 256,
    parameter int          LOCK_TIMEOUT = 4096,
    parameter int          SYNC_LEN     = 4,
    parameter logic [7:0]  SYNC_WORD    = 8'h5A,
    parameter logic [7:0]  IDLE_WORD    = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LINK_EN,
    input  logic       RETRAIN,
    input  logic       PEER_LOCKED,
    output logic       TP_RST,
    input  logic [7:0] TP_DATA,
    input  logic [7:0] TX_DATA_IN,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] DATA_OUT,
    output logic       LINK_UP,
    output logic       TRAIN_ACTIVE,
    output logic       TIMEOUT_ERR
);

    localparam int MAX_P = (TRAIN_CYCLES > LOCK_TIMEOUT)
                         ? ((TRAIN_CYCLES > SYNC_LEN) ? TRAIN_CYCLES : SYNC_LEN)
                         : ((LOCK_TIMEOUT > SYNC_LEN) ? LOCK_TIMEOUT : SYNC_LEN);
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_TRAIN,
        S_WAIT_LOCK,
        S_SYNC,
        S_UP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       data_q;
    logic             timeout_q;

    logic train_done;
    logic lock_expired;
    logic sync_done;

    assign train_done   = (cnt_q == CNT_W'(TRAIN_CYCLES - 1));
    assign lock_expired = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
    assign sync_done    = (cnt_q == CNT_W'(SYNC_LEN - 1));

    // Status outputs depend on the state register alone, so they never glitch with inputs.
    assign TP_RST       = (state_q == S_OFF) || (state_q == S_SYNC) || (state_q == S_UP);
    assign TRAIN_ACTIVE = (state_q == S_TRAIN) || (state_q == S_WAIT_LOCK);
    assign LINK_UP      = (state_q == S_UP);
    assign TX_READY     = (state_q == S_UP);
    assign DATA_OUT     = data_q;
    assign TIMEOUT_ERR  = timeout_q;

    // NOTE: reset here is synchronous (inside the clocked branch), and every state
    // element uses <= so all registers see the pre-edge values of each other.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            data_q    <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            // Lane contents follow the state being left, not the state being entered.
            case (state_q)
                S_TRAIN, S_WAIT_LOCK: data_q <= TP_DATA;
                S_SYNC:               data_q <= SYNC_WORD;
                S_UP:                 data_q <= TX_VALID ? TX_DATA_IN : IDLE_WORD;
                default:              data_q <= 8'h00;
            endcase

            if ((state_q == S_TRAIN) || (state_q == S_WAIT_LOCK) || (state_q == S_SYNC)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            if (!LINK_EN) begin
                state_q   <= S_OFF;
                cnt_q     <= '0;
                data_q    <= 8'h00;
                timeout_q <= 1'b0;
            end else if (RETRAIN && (state_q != S_OFF)) begin
                state_q <= S_TRAIN;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        state_q <= S_TRAIN;
                        cnt_q   <= '0;
                    end
                    S_TRAIN: begin
                        if (train_done) begin
                            state_q <= S_WAIT_LOCK;
                            cnt_q   <= '0;
                        end
                    end
                    S_WAIT_LOCK: begin
                        // Lock is tested first so a coincident timeout is ignored.
                        if (PEER_LOCKED) begin
                            state_q <= S_SYNC;
                            cnt_q   <= '0;
                        end else if (lock_expired) begin
                            state_q   <= S_TRAIN;
                            cnt_q     <= '0;
                            timeout_q <= 1'b1;
                        end
                    end
                    S_SYNC: begin
                        if (!PEER_LOCKED) begin
                            state_q <= S_TRAIN;
                            cnt_q   <= '0;
                        end else if (sync_done) begin
                            state_q <= S_UP;
                            cnt_q   <= '0;
                        end
                    end
                    S_UP: begin
                        if (!PEER_LOCKED) begin
                            state_q <= S_TRAIN;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_OFF;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rcb_frl_tx_link_ctrl.sv
// Directed bench: the driver queues hand-computed expectations per cycle and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_rcb_frl_tx_link_ctrl;

    localparam int TC = 8;
    localparam int LT = 16;
    localparam int SL = 4;

    typedef enum {S_OFF, S_TRN, S_WT, S_SYN, S_UP} tst_e;

    typedef struct {
        int         due;
        logic [4:0] flags;
        bit         chk_d;
        logic [7:0] d;
        string      nm;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST, LINK_EN, RETRAIN, PEER_LOCKED, TX_VALID;
    logic [7:0] TX_DATA_IN;
    logic [7:0] TP_DATA = 8'h00;
    logic [7:0] DATA_OUT;
    logic       TP_RST, TX_READY, LINK_UP, TRAIN_ACTIVE, TIMEOUT_ERR;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Training-pattern generator: held at 0x00 in reset, then F4, C2, F4, ...
    always @(posedge CLK) begin
        if (TP_RST !== 1'b0) TP_DATA <= 8'h00;
        else                 TP_DATA <= (TP_DATA == 8'hF4) ? 8'hC2 : 8'hF4;
    end

    rcb_frl_tx_link_ctrl #(
        .TRAIN_CYCLES(TC),
        .LOCK_TIMEOUT(LT),
        .SYNC_LEN    (SL),
        .SYNC_WORD   (8'h5A),
        .IDLE_WORD   (8'h00)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .LINK_EN     (LINK_EN),
        .RETRAIN     (RETRAIN),
        .PEER_LOCKED (PEER_LOCKED),
        .TP_RST      (TP_RST),
        .TP_DATA     (TP_DATA),
        .TX_DATA_IN  (TX_DATA_IN),
        .TX_VALID    (TX_VALID),
        .TX_READY    (TX_READY),
        .DATA_OUT    (DATA_OUT),
        .LINK_UP     (LINK_UP),
        .TRAIN_ACTIVE(TRAIN_ACTIVE),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // {LINK_UP, TRAIN_ACTIVE, TP_RST, TX_READY}
    function automatic logic [3:0] flags_of(input tst_e s);
        case (s)
            S_OFF:   return 4'b0010;
            S_TRN:   return 4'b0100;
            S_WT:    return 4'b0100;
            S_SYN:   return 4'b0010;
            default: return 4'b1011;
        endcase
    endfunction

    // Inputs are already set; queue the outputs expected after the next edge, then step.
    task automatic tick(input tst_e st, input bit to, input bit chk_d,
                        input logic [7:0] d, input string nm);
        exp_t e;
        e.due   = cyc + 1;
        e.flags = {flags_of(st), to};
        e.chk_d = chk_d;
        e.d     = d;
        e.nm    = nm;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            if (sb[0].due <= cyc) begin
                e = sb.pop_front();
                if (e.due < cyc) check({e.nm, "_stale"}, 8'(cyc - e.due), 8'h00);
                check({e.nm, "_flags"},
                      {3'b000, LINK_UP, TRAIN_ACTIVE, TP_RST, TX_READY, TIMEOUT_ERR},
                      {3'b000, e.flags});
                if (e.chk_d) check({e.nm, "_data"}, DATA_OUT, e.d);
            end
        end
    end

    // Starts from OFF with the generator held; ends on the first UP cycle.
    task automatic bring_up(input string tag);
        LINK_EN = 1'b1; PEER_LOCKED = 1'b1; RETRAIN = 1'b0; TX_VALID = 1'b0;
        tick(S_TRN, 0, 1, 8'h00, {tag, "_enter"});
        tick(S_TRN, 0, 1, 8'h00, {tag, "_tp0"});
        for (int i = 0; i < 6; i++) tick(S_TRN, 0, 1, (i % 2 == 0) ? 8'hF4 : 8'hC2, {tag, "_tp"});
        tick(S_WT,  0, 1, 8'hF4, {tag, "_wait"});
        tick(S_SYN, 0, 1, 8'hC2, {tag, "_wait_byte"});
        for (int i = 0; i < 3; i++) tick(S_SYN, 0, 1, 8'h5A, {tag, "_sync"});
        tick(S_UP,  0, 1, 8'h5A, {tag, "_up"});
    endtask

    initial begin
        RST = 1'b1; LINK_EN = 1'b0; RETRAIN = 1'b0; PEER_LOCKED = 1'b0;
        TX_VALID = 1'b0; TX_DATA_IN = 8'h00;
        repeat (4) tick(S_OFF, 0, 1, 8'h00, "reset");
        RST = 1'b0;

        bring_up("bu");

        TX_VALID = 1'b1; TX_DATA_IN = 8'h11; tick(S_UP, 0, 1, 8'h11, "d11");
        TX_DATA_IN = 8'h22;                  tick(S_UP, 0, 1, 8'h22, "d22");
        TX_VALID = 1'b0;                     tick(S_UP, 0, 1, 8'h00, "d_gap");
        TX_VALID = 1'b1; TX_DATA_IN = 8'h33; tick(S_UP, 0, 1, 8'h33, "d33");

        // One-cycle lock drop while a byte is offered: byte goes out, training restarts.
        TX_DATA_IN = 8'h77; PEER_LOCKED = 1'b0; tick(S_TRN, 0, 1, 8'h77, "loss_byte");
        TX_VALID = 1'b0; PEER_LOCKED = 1'b1;
        tick(S_TRN, 0, 1, 8'h00, "loss_tp0");
        tick(S_TRN, 0, 1, 8'hF4, "loss_tp1");

        // Retrain mid-burst, then a full burst followed by a lock timeout.
        RETRAIN = 1'b1; PEER_LOCKED = 1'b0; tick(S_TRN, 0, 1, 8'hC2, "retrain");
        RETRAIN = 1'b0;
        for (int j = 1; j < 8; j++) tick(S_TRN, 0, 1, (j % 2) ? 8'hF4 : 8'hC2, "retrain_burst");
        tick(S_WT, 0, 1, 8'hC2, "retrain_wait");
        for (int j = 9; j < 24; j++) tick(S_WT, 0, 1, (j % 2) ? 8'hF4 : 8'hC2, "wait_nolock");
        tick(S_TRN, 1, 1, 8'hC2, "timeout");
        tick(S_TRN, 1, 1, 8'hF4, "timeout_sticky");
        LINK_EN = 1'b0; tick(S_OFF, 0, 1, 8'h00, "timeout_clear");

        // LINK_EN low outranks RETRAIN.
        bring_up("pri");
        RETRAIN = 1'b1; LINK_EN = 1'b0; TX_VALID = 1'b1; TX_DATA_IN = 8'h99;
        tick(S_OFF, 0, 1, 8'h00, "prio_off");
        RETRAIN = 1'b0; TX_VALID = 1'b0;

        // Lock arrives on the very cycle the timeout would fire.
        LINK_EN = 1'b1; PEER_LOCKED = 1'b0;
        repeat (TC) tick(S_TRN, 0, 0, 8'h00, "sim_train");
        repeat (LT) tick(S_WT, 0, 0, 8'h00, "sim_wait");
        PEER_LOCKED = 1'b1; tick(S_SYN, 0, 0, 8'h00, "sim_lock_wins");
        PEER_LOCKED = 1'b0; tick(S_TRN, 0, 1, 8'h5A, "sync_loss");

        // Reset mid-operation drops the in-flight byte.
        LINK_EN = 1'b0; tick(S_OFF, 0, 1, 8'h00, "pre_rst_off");
        bring_up("rst");
        TX_VALID = 1'b1; TX_DATA_IN = 8'hAB; RST = 1'b1;
        tick(S_OFF, 0, 1, 8'h00, "rst_midop");
        RST = 1'b0; TX_VALID = 1'b0; LINK_EN = 1'b0;
        tick(S_OFF, 0, 1, 8'h00, "rst_hold");

        repeat (2) @(negedge CLK);
        check("sb_drain", 8'(sb.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
